twos_comp_decoder: RTL and testbench

TWOS_COMP_DECODER -- requirements
Module: twos_comp_decoder

---
 rtl/twos_comp_decoder.sv | 100 ++++++++++
 tb/tb_twos_comp_decoder.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/twos_comp_decoder.sv
// rtl/twos_comp_decoder.sv - bit-serial two's-complement to sign/magnitude decoder
// Optional feature macro: TWOS_DEC_OVF_FLAG_EN (adds out_ovf for the most-negative input)

module twos_comp_decoder #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             out_sign,
   output logic [WIDTH-1:0] out_mag,
   output logic             out_valid,
   input  logic             out_ready
`ifdef TWOS_DEC_OVF_FLAG_EN
   ,
   output logic             out_ovf
`endif
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] shreg;
   logic [CW-1:0]    cnt;
   logic             seen;
   logic             obit;

   // Once a one has been seen in a negative word, every higher bit is inverted
   // (copy-through-first-one, then complement), which yields the magnitude.
   assign obit = shreg[0] ^ (out_sign & seen);

   // Control FSM and datapath; all outputs are registered here.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_sign  <= 1'b0;
         out_mag   <= '0;
         shreg     <= '0;
         cnt       <= '0;
         seen      <= 1'b0;
`ifdef TWOS_DEC_OVF_FLAG_EN
         out_ovf   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  shreg    <= in_data;
                  out_sign <= in_data[WIDTH-1];
                  cnt      <= '0;
                  seen     <= 1'b0;
                  in_ready <= 1'b0;
                  state    <= SHIFT;
               end
            end
            SHIFT: begin
               shreg   <= shreg >> 1;
               out_mag <= {obit, out_mag[WIDTH-1:1]};
               seen    <= seen | shreg[0];
               cnt     <= cnt + 1'b1;
               if (cnt == LAST_BIT) begin
                  out_valid <= 1'b1;
                  state     <= DONE;
`ifdef TWOS_DEC_OVF_FLAG_EN
                  // Negative with no ones below the MSB is exactly 100..0.
                  out_ovf   <= out_sign & ~seen;
`endif
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
`ifdef TWOS_DEC_OVF_FLAG_EN
                  out_ovf   <= 1'b0;
`endif
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_twos_comp_decoder.sv
// tb/tb_twos_comp_decoder.sv - directed self-checking bench for twos_comp_decoder

module tb_twos_comp_decoder;

   localparam int W = 4;

   logic         clk;
   logic         rst;
   logic [W-1:0] in_data;
   logic         in_valid;
   logic         in_ready;
   logic         out_sign;
   logic [W-1:0] out_mag;
   logic         out_valid;
   logic         out_ready;
   logic         ovf_obs;
`ifdef TWOS_DEC_OVF_FLAG_EN
   logic         out_ovf;
   assign ovf_obs = out_ovf;
`else
   assign ovf_obs = 1'b0;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   twos_comp_decoder #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_sign  (out_sign),
      .out_mag   (out_mag),
      .out_valid (out_valid),
      .out_ready (out_ready)
`ifdef TWOS_DEC_OVF_FLAG_EN
      ,
      .out_ovf   (out_ovf)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Accept one word, then wait (bounded) for out_valid; lat = -1 on timeout.
   task automatic send_word(input logic [W-1:0] d, output int lat,
                            output logic s, output logic [W-1:0] m, output logic o);
      in_data  = d;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         tick();
         lat++;
      end
      if (!out_valid) lat = -1;
      s = out_sign;
      m = out_mag;
      o = ovf_obs;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b1; in_data = 4'b1011; out_ready = 1'b1;
      tick();
      tick();
      rst = 1'b0; in_valid = 1'b0;
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sign !== 1'b0 || out_mag !== 4'b0000 || ovf_obs !== 1'b0) begin
         n_fail++;
         $display("FAIL reset: in_ready=%b out_valid=%b sign=%b mag=%b ovf=%b, need 1 0 0 0000 0",
                  in_ready, out_valid, out_sign, out_mag, ovf_obs);
      end
   endtask

   task automatic test_decode_vectors();
      localparam logic [W-1:0] VIN  [6] = '{4'b0101, 4'b1011, 4'b1111, 4'b0000, 4'b1000, 4'b0111};
      localparam logic         VSGN [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      localparam logic [W-1:0] VMAG [6] = '{4'b0101, 4'b0101, 4'b0001, 4'b0000, 4'b1000, 4'b0111};
      localparam logic         VOVF [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      int lat;
      logic s, o;
      logic [W-1:0] m;
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         send_word(VIN[i], lat, s, m, o);
         n_checks++;
         if (lat !== W) begin
            n_fail++;
            $display("FAIL latency[%b]: got %0d cycles, need %0d", VIN[i], lat, W);
         end
         n_checks++;
         if (s !== VSGN[i] || m !== VMAG[i]) begin
            n_fail++;
            $display("FAIL decode[%b]: sign=%b mag=%b, need sign=%b mag=%b", VIN[i], s, m, VSGN[i], VMAG[i]);
         end
`ifdef TWOS_DEC_OVF_FLAG_EN
         n_checks++;
         if (o !== VOVF[i]) begin
            n_fail++;
            $display("FAIL ovf[%b]: got %b, need %b", VIN[i], o, VOVF[i]);
         end
`else
         if (o !== 1'b0 && VOVF[i] === 1'bx) $display("unreachable");
`endif
         tick();
         n_checks++;
         if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL release[%b]: in_ready=%b out_valid=%b, need 1 0", VIN[i], in_ready, out_valid);
         end
      end
   endtask

   task automatic test_backpressure();
      int lat;
      logic s, o;
      logic [W-1:0] m;
      out_ready = 1'b0;
      send_word(4'b1011, lat, s, m, o);
      n_checks++;
      if (lat !== W || s !== 1'b1 || m !== 4'b0101) begin
         n_fail++;
         $display("FAIL bp_first: lat=%0d sign=%b mag=%b, need %0d 1 0101", lat, s, m, W);
      end
      for (int c = 0; c < 3; c++) begin
         in_valid = ~in_valid;
         in_data  = 4'b0001;
         tick();
         n_checks++;
         if (out_valid !== 1'b1 || out_sign !== 1'b1 || out_mag !== 4'b0101 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_hold[%0d]: valid=%b sign=%b mag=%b in_ready=%b, need 1 1 0101 0",
                     c, out_valid, out_sign, out_mag, in_ready);
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_release: valid=%b in_ready=%b, need 0 1", out_valid, in_ready);
      end
      tick();
      tick();
      n_checks++;
      if (out_sign !== 1'b1 || out_mag !== 4'b0101 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL idle_stable: sign=%b mag=%b in_ready=%b, need 1 0101 1", out_sign, out_mag, in_ready);
      end
   endtask

   task automatic test_reset_mid_shift();
      int lat;
      logic s, o;
      logic [W-1:0] m;
      out_ready = 1'b1;
      in_data   = 4'b1010;
      in_valid  = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_shift: in_ready=%b valid=%b, need 1 0", in_ready, out_valid);
      end
      send_word(4'b0011, lat, s, m, o);
      n_checks++;
      if (lat !== W || s !== 1'b0 || m !== 4'b0011) begin
         n_fail++;
         $display("FAIL after_rst: lat=%0d sign=%b mag=%b, need %0d 0 0011", lat, s, m, W);
      end
      tick();
   endtask

   task automatic test_reset_in_done();
      int lat;
      logic s, o;
      logic [W-1:0] m;
      out_ready = 1'b0;
      send_word(4'b1100, lat, s, m, o);
      n_checks++;
      if (lat !== W || s !== 1'b1 || m !== 4'b0100) begin
         n_fail++;
         $display("FAIL pre_rst_done: lat=%0d sign=%b mag=%b, need %0d 1 0100", lat, s, m, W);
      end
      rst = 1'b1; out_ready = 1'b1;
      tick();
      rst = 1'b0; out_ready = 1'b0;
      n_checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_mag !== 4'b0000 || out_sign !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_done: in_ready=%b valid=%b sign=%b mag=%b, need 1 0 0 0000",
                  in_ready, out_valid, out_sign, out_mag);
      end
   endtask

   task automatic test_back_to_back();
      int   nres = 0;
      int   cyc[2];
      logic sg[2];
      logic [W-1:0] mg[2];
      logic rdy5 = 1'b0;
      cyc[0] = -1; cyc[1] = -1;
      out_ready = 1'b1;
      in_data   = 4'b1110;
      in_valid  = 1'b1;
      tick();
      in_data = 4'b0010;
      for (int c = 1; c <= 2 * W + 3; c++) begin
         tick();
         if (c == W + 1) rdy5 = in_ready;
         if (out_valid && nres < 2) begin
            cyc[nres] = c;
            sg[nres]  = out_sign;
            mg[nres]  = out_mag;
            nres++;
         end
      end
      in_valid = 1'b0;
      n_checks++;
      if (nres !== 2) begin
         n_fail++;
         $display("FAIL b2b_count: got %0d results, need 2", nres);
      end else begin
         n_checks++;
         if (cyc[0] !== W || sg[0] !== 1'b1 || mg[0] !== 4'b0010) begin
            n_fail++;
            $display("FAIL b2b_first: cycle=%0d sign=%b mag=%b, need %0d 1 0010", cyc[0], sg[0], mg[0], W);
         end
         n_checks++;
         if (cyc[1] !== 2 * W + 2 || sg[1] !== 1'b0 || mg[1] !== 4'b0010) begin
            n_fail++;
            $display("FAIL b2b_second: cycle=%0d sign=%b mag=%b, need %0d 0 0010", cyc[1], sg[1], mg[1], 2 * W + 2);
         end
      end
      n_checks++;
      if (rdy5 !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_ready: in_ready=%b after first handshake, need 1", rdy5);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      test_reset();
      test_decode_vectors();
      test_backpressure();
      test_reset_mid_shift();
      test_reset_in_done();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation exceeded time limit, need completion");
      $fatal(1, "timeout");
   end

endmodule
